// File: rtl/alu_serie.sv
// alu_serie: bit-serial ALU. Operands are processed LSB-first, one bit per
// clock, through a single cal cell, with the carry held in a register
// between bit-cycles.
// Optional feature macro: ALU_SERIE_OVF_EN. When it is defined, the signed
// overflow flag is built. When it is undefined, ovf is tied to 0. The port
// list is the same in both builds.

// One-bit arithmetic/logic cell: a full adder, or a 2-bit-selected logic function.
module cal (
  input  logic       a,
  input  logic       b,
  input  logic       l,
  input  logic [1:0] s,
  input  logic       c_in,
  output logic       out,
  output logic       c_out
);

  // Select the sum/carry or the logic function result.
  always_comb begin
    out   = 1'b0;
    c_out = 1'b0;
    if (!l) begin
      out   = a ^ b ^ c_in;
      c_out = (a & b) | (a & c_in) | (b & c_in);
    end else begin
      unique case (s)
        2'b00:   out = a & b;
        2'b01:   out = a | b;
        2'b10:   out = a ^ b;
        default: out = ~a;
      endcase
    end
  end

endmodule

module alu_serie #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             l,
  input  logic [1:0]       s,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic             l_q;
  logic [1:0]       s_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic             cell_out;
  logic             cell_cout;
  logic [WIDTH-1:0] next_res;

  cal u_cal (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .l     (l_q),
    .s     (s_q),
    .c_in  (carry_q),
    .out   (cell_out),
    .c_out (cell_cout)
  );

  // The result after the current bit-cycle: the new bit enters at the MSB.
  always_comb begin
    next_res = {cell_out, res_sh};
  end

  // Sequencer: operand latch, serial shift, and result/flag capture on the last bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      l_q     <= 1'b0;
      s_q     <= 2'b00;
      carry_q <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      out     <= '0;
      c_out   <= 1'b0;
      zero    <= 1'b0;
`ifdef ALU_SERIE_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            l_q     <= l;
            s_q     <= s;
            carry_q <= l ? 1'b0 : c_in;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          res_sh  <= next_res[WIDTH-1:1];
          carry_q <= l_q ? 1'b0 : cell_cout;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            out   <= next_res;
            c_out <= ~l_q & cell_cout;
            zero  <= (next_res == '0);
`ifdef ALU_SERIE_OVF_EN
            // carry_q is the carry into the MSB during this final bit-cycle
            ovf   <= ~l_q & (carry_q ^ cell_cout);
`endif
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef ALU_SERIE_OVF_EN
  // Overflow logic is not built in this configuration.
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serie.sv
// Directed-vector bench for alu_serie (WIDTH=4).
module tb_alu_serie;

  localparam int unsigned WIDTH = 4;
`ifdef ALU_SERIE_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_l;
  logic [1:0]       op_s;
  logic             op_cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic             c_out;
  logic             zero;
  logic             ovf;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  alu_serie #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (op_a),
    .b       (op_b),
    .l       (op_l),
    .s       (op_s),
    .c_in    (op_cin),
    .busy    (busy),
    .done    (done),
    .out     (res),
    .c_out   (c_out),
    .zero    (zero),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete operation, checking latency, result, flags and the one-cycle done pulse.
  task automatic run_op(input string tag, input logic [3:0] va, input logic [3:0] vb,
                        input logic vl, input logic [1:0] vs, input logic vcin,
                        input logic [3:0] e_out, input logic e_c, input logic e_z,
                        input logic e_v);
    int cyc;
    @(negedge clk);
    op_a = va; op_b = vb; op_l = vl; op_s = vs; op_cin = vcin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'd4);
    chk({tag, ".out"}, 32'(res), 32'(e_out));
    chk({tag, ".c_out"}, 32'(c_out), 32'(e_c));
    chk({tag, ".zero"}, 32'(zero), 32'(e_z));
    chk({tag, ".ovf"}, 32'(ovf), 32'(e_v));
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".done_1cyc"}, 32'(done), 32'd0);
    chk({tag, ".out_hold"}, 32'(res), 32'(e_out));
  endtask

  initial begin
    int d0;
    int cyc;
    int last_t;
    int n;
    reset_n = 1'b0; start = 1'b0;
    op_a = '0; op_b = '0; op_l = 1'b0; op_s = 2'b00; op_cin = 1'b0;
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.out", 32'(res), 32'd0);
    chk("rst.flags", 32'({c_out, zero, ovf}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("add7p1",  4'b0111, 4'b0001, 1'b0, 2'b00, 1'b0, 4'b1000, 1'b0, 1'b0, OVF_EN);
    run_op("addwrap", 4'b1111, 4'b0001, 1'b0, 2'b00, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
    run_op("sub5m3",  4'b0101, 4'b1100, 1'b0, 2'b00, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
    run_op("and",     4'b1100, 4'b1010, 1'b1, 2'b00, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0);
    run_op("or",      4'b1100, 4'b1010, 1'b1, 2'b01, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0);
    run_op("xor",     4'b1100, 4'b1010, 1'b1, 2'b10, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0);
    run_op("nota",    4'b1100, 4'b1010, 1'b1, 2'b11, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);

    // start pulsed mid-SHIFT with other operands is ignored
    d0 = done_cnt;
    @(negedge clk);
    op_a = 4'b0111; op_b = 4'b0001; op_l = 1'b0; op_s = 2'b00; op_cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    op_a = 4'b1111; op_b = 4'b1111; op_l = 1'b1; op_s = 2'b01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("midstart.out", 32'(res), 32'h8);
    chk("midstart.c_out", 32'(c_out), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("midstart.done_once", 32'(done_cnt - d0), 32'd1);

    // reset after two bit-cycles discards the operation
    @(negedge clk);
    op_a = 4'b0011; op_b = 4'b0011; op_l = 1'b0; op_cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.out", 32'(res), 32'd0);
    chk("midrst.flags", 32'({c_out, zero, ovf}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    d0 = done_cnt;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst.no_done", 32'(done_cnt - d0), 32'd0);
    run_op("postrst", 4'b0011, 4'b0011, 1'b0, 2'b00, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0);

    // start held high: re-trigger every WIDTH+2 cycles; a changed while busy
    @(negedge clk);
    op_a = 4'b0011; op_b = 4'b0001; op_l = 1'b0; op_s = 2'b00; op_cin = 1'b0; start = 1'b1;
    last_t = 0;
    n = 0;
    for (int t = 1; t <= 20; t++) begin
      @(posedge clk); #1;
      if (t == 2) op_a = 4'b0101;
      if (done === 1'b1) begin
        chk($sformatf("hold.out%0d", n), 32'(res), (n == 0) ? 32'h4 : 32'h6);
        if (last_t == 0) chk("hold.first_t", 32'(t), 32'd5);
        else chk($sformatf("hold.gap%0d", n), 32'(t - last_t), 32'd6);
        last_t = t;
        n++;
      end
    end
    start = 1'b0;
    chk("hold.count", 32'(n), 32'd3);
    repeat (8) @(posedge clk);
    #1;
    chk("hold.final_out", 32'(res), 32'h6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
